toggle_port_responder: RTL

//  Memory-side end of the toggle req/ack port used by the ROM loader (portN_req/portN_ack/_a/_ds/_we/_d/_q).

---
 rtl/toggle_port_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/toggle_port_responder.sv
// Memory-side responder for the toggle req/ack port: one memory word cycle per req toggle, then ack toggles.
// Optional watchdog on the memory handshake is enabled by defining TPR_TIMEOUT_EN.
module toggle_port_responder #(
    parameter int unsigned AW          = 23,
    parameter int unsigned DW          = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          port_req,
    output logic          port_ack,
    input  logic [AW-1:0] port_a,
    input  logic [DW/8-1:0] port_ds,
    input  logic          port_we,
    input  logic [DW-1:0] port_d,
    output logic [DW-1:0] port_q,
    output logic          mem_cs,
    input  logic          mem_gnt,
    input  logic          mem_rdy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_q,
    output logic          busy,
    output logic          err
);

    localparam int unsigned BW = DW / 8;

    // Reject parameter sets the datapath cannot support.
    if (SYNC_STAGES < 2 || (DW != 16 && DW != 32) || TIMEOUT > 255) begin : g_param_check
        $error("toggle_port_responder: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CAPT  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   pending_c;

    logic                   port_ack_d;
    logic [DW-1:0]          port_q_d;
    logic                   mem_cs_d;
    logic [AW-1:0]          mem_addr_d;
    logic                   mem_we_d;
    logic [BW-1:0]          mem_be_d;
    logic [DW-1:0]          mem_d_d;
    logic                   busy_d;

`ifdef TPR_TIMEOUT_EN
    logic [7:0]             cnt, cnt_d;
    logic                   err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Bring the initiator's req toggle into this clock domain.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], port_req};
        end
    end

    assign req_s     = req_sync[SYNC_STAGES-1];
    assign pending_c = req_s ^ port_ack;

    // State and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            port_ack <= 1'b0;
            port_q   <= '0;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            mem_d    <= '0;
            busy     <= 1'b0;
`ifdef TPR_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            port_ack <= port_ack_d;
            port_q   <= port_q_d;
            mem_cs   <= mem_cs_d;
            mem_addr <= mem_addr_d;
            mem_we   <= mem_we_d;
            mem_be   <= mem_be_d;
            mem_d    <= mem_d_d;
            busy     <= busy_d;
`ifdef TPR_TIMEOUT_EN
            cnt      <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        port_ack_d = port_ack;
        port_q_d   = port_q;
        mem_addr_d = mem_addr;
        mem_we_d   = mem_we;
        mem_be_d   = mem_be;
        mem_d_d    = mem_d;
`ifdef TPR_TIMEOUT_EN
        cnt_d      = cnt;
        err_d      = err_q;
`endif

        case (state)
            S_IDLE: begin
                if (pending_c) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                mem_addr_d = port_a;
                mem_d_d    = port_d;
                mem_we_d   = port_we;
                mem_be_d   = port_we ? port_ds : {BW{1'b1}};
`ifdef TPR_TIMEOUT_EN
                cnt_d      = '0;
`endif
                // A write with no lanes enabled completes without touching memory.
                if (port_we && (port_ds == '0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    if (mem_rdy) begin
                        if (!mem_we) begin
                            port_q_d = mem_q;
                        end
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rdy) begin
                    if (!mem_we) begin
                        port_q_d = mem_q;
                    end
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                port_ack_d = ~port_ack;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef TPR_TIMEOUT_EN
        // Watchdog: abandon a stalled memory cycle and flag it.
        if ((state == S_ISSUE || state == S_WAIT) && state_d != S_DONE) begin
            if (cnt == 8'(TIMEOUT)) begin
                state_d = S_DONE;
                err_d   = 1'b1;
                if (!mem_we) begin
                    port_q_d = {(DW/16){16'hDEAD}};
                end
            end else begin
                cnt_d = cnt + 8'd1;
            end
        end
`endif

        mem_cs_d = (state_d == S_ISSUE);
        busy_d   = (state_d != S_IDLE);
    end

endmodule
